usb_rx_deserializer: RTL and testbench

//  - HS USB2 receive stage directly downstream of CRD. Consumes the recovered bit stream: CRD bit with ADD/DROP slip flags.
//  - Performs NRZI decode, SYNC hunt, bit unstuffing and LSB-first byte assembly.
//  - Marks packet boundaries, using the HS EOP bit-stuff violation as end of packet. Feeds the byte-level packet decoder.

---
 rtl/usb_rx_deserializer_pkg.sv | 32 +++
 rtl/usb_rx_deserializer_if.sv | 34 +++
 rtl/usb_rx_deserializer_bitstep.sv | 72 +++++++
 rtl/usb_rx_deserializer.sv | 123 ++++++++++++
 tb/tb_usb_rx_deserializer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types and constants for the HS USB receive deserializer.
// The optional statistics counters are enabled with USB_RX_STATS_EN.
package usb_rx_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } rx_state_t;

    localparam logic J_LEVEL    = 1'b1;
    localparam int   USB_BYTE_W = 8;

    typedef struct packed {
        logic                  prev_line;
        logic [4:0]            zero_cnt;
        logic [3:0]            ones_cnt;
        logic [2:0]            bit_cnt;
        logic [USB_BYTE_W-1:0] shreg;
        rx_state_t             state;
    } rx_bit_state_t;

    // Idle line is J, so the first K after reset decodes as a zero.
    localparam rx_bit_state_t RX_RESET_STATE = '{
        prev_line: J_LEVEL,
        zero_cnt:  5'd0,
        ones_cnt:  4'd0,
        bit_cnt:   3'd0,
        shreg:     '0,
        state:     HUNT
    };

endpackage

// File: rtl/usb_rx_deserializer_if.sv
// Bit-stream input and byte/packet output bundle of the USB receive deserializer.
// pkt_count/err_count exist only when USB_RX_STATS_EN is defined.
interface usb_rx_deserializer_if;

    logic                             crd;
    logic                             add;
    logic                             drop;
    logic                             rx_active;
    logic                             rx_valid;
    logic [usb_rx_pkg::USB_BYTE_W-1:0] rx_data;
    logic                             rx_eop;
    logic                             rx_err;
`ifdef USB_RX_STATS_EN
    logic [15:0]                      pkt_count;
    logic [15:0]                      err_count;
`endif

    modport master (
        output crd, add, drop,
`ifdef USB_RX_STATS_EN
        input  pkt_count, err_count,
`endif
        input  rx_active, rx_valid, rx_data, rx_eop, rx_err
    );

    modport slave (
        input  crd, add, drop,
`ifdef USB_RX_STATS_EN
        output pkt_count, err_count,
`endif
        output rx_active, rx_valid, rx_data, rx_eop, rx_err
    );

endinterface

// File: rtl/usb_rx_deserializer_bitstep.sv
// Combinational next-state function for one received line bit:
// NRZI decode, SYNC hunt, bit unstuffing and LSB-first byte shifting.
module usb_rx_bitstep
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN  = 12,
    parameter int STUFF_LEN = 6
) (
    input  rx_bit_state_t          cur,
    input  logic                   line,
    input  logic                   en,
    output rx_bit_state_t          nxt,
    output logic                   sync_hit,
    output logic                   byte_done,
    output logic [USB_BYTE_W-1:0]  byte_val,
    output logic                   eop
);

    logic d;

    assign d        = (line == cur.prev_line);
    assign byte_val = {d, cur.shreg[USB_BYTE_W-1:1]};

    always_comb begin
        nxt       = cur;
        sync_hit  = 1'b0;
        byte_done = 1'b0;
        eop       = 1'b0;
        if (en) begin
            nxt.prev_line = line;
            case (cur.state)
                HUNT: begin
                    if (!d) begin
                        if (cur.zero_cnt >= 5'(SYNC_MIN)) begin
                            nxt.zero_cnt = 5'(SYNC_MIN);
                        end else begin
                            nxt.zero_cnt = cur.zero_cnt + 5'd1;
                        end
                    end else if (cur.zero_cnt >= 5'(SYNC_MIN)) begin
                        nxt.state    = DATA;
                        nxt.zero_cnt = 5'd0;
                        nxt.bit_cnt  = 3'd0;
                        nxt.ones_cnt = 4'd1;
                        sync_hit     = 1'b1;
                    end else begin
                        nxt.zero_cnt = 5'd0;
                    end
                end
                DATA: begin
                    // A one in the stuff slot cannot be data, so it marks end of packet.
                    if (cur.ones_cnt == 4'(STUFF_LEN)) begin
                        if (!d) begin
                            nxt.ones_cnt = 4'd0;
                        end else begin
                            eop          = 1'b1;
                            nxt.state    = HUNT;
                            nxt.zero_cnt = 5'd0;
                            nxt.ones_cnt = 4'd0;
                            nxt.bit_cnt  = 3'd0;
                        end
                    end else begin
                        nxt.shreg    = byte_val;
                        nxt.ones_cnt = d ? cur.ones_cnt + 4'd1 : 4'd0;
                        nxt.bit_cnt  = cur.bit_cnt + 3'd1;
                        byte_done    = (cur.bit_cnt == 3'(USB_BYTE_W - 1));
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/usb_rx_deserializer.sv
// HS USB receive deserializer: turns CRD bits (with add/drop slips) into bytes and packet strobes.
// Define USB_RX_STATS_EN to add the pkt_count/err_count statistics outputs.
module usb_rx_deserializer
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN  = 12,
    parameter int STUFF_LEN = 6
) (
    input logic                  clock,
    input logic                  reset,
    usb_rx_deserializer_if.slave rx
);

    rx_bit_state_t         st_q, st_mid, st_d;
    logic                  en0, en1;
    logic                  sync0, sync1, done0, done1, eop0, eop1;
    logic [USB_BYTE_W-1:0] val0, val1;
    logic                  byte_cnt_q, byte_cnt_mid, byte_cnt_d;
    logic                  err0, err1;
    logic                  rx_active_q, rx_active_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [USB_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_eop_q, rx_eop_d;
    logic                  rx_err_q, rx_err_d;

    // drop wins over add; nothing after an EOP bit is processed in the same cycle.
    assign en0 = ~rx.drop;
    assign en1 = rx.add & ~rx.drop & ~eop0;

    usb_rx_bitstep #(.SYNC_MIN(SYNC_MIN), .STUFF_LEN(STUFF_LEN)) u_bit0 (
        .cur       (st_q),
        .line      (rx.crd),
        .en        (en0),
        .nxt       (st_mid),
        .sync_hit  (sync0),
        .byte_done (done0),
        .byte_val  (val0),
        .eop       (eop0)
    );

    usb_rx_bitstep #(.SYNC_MIN(SYNC_MIN), .STUFF_LEN(STUFF_LEN)) u_bit1 (
        .cur       (st_mid),
        .line      (rx.crd),
        .en        (en1),
        .nxt       (st_d),
        .sync_hit  (sync1),
        .byte_done (done1),
        .byte_val  (val1),
        .eop       (eop1)
    );

    always_comb begin
        byte_cnt_mid = byte_cnt_q;
        if (sync0) begin
            byte_cnt_mid = 1'b0;
        end else if (done0) begin
            byte_cnt_mid = 1'b1;
        end
        byte_cnt_d = byte_cnt_mid;
        if (sync1) begin
            byte_cnt_d = 1'b0;
        end else if (done1) begin
            byte_cnt_d = 1'b1;
        end
        err0        = eop0 & ~byte_cnt_q;
        err1        = eop1 & ~byte_cnt_mid;
        rx_valid_d  = done0 | done1;
        rx_data_d   = done1 ? val1 : (done0 ? val0 : rx_data_q);
        rx_eop_d    = eop0 | eop1;
        rx_err_d    = err0 | err1;
        rx_active_d = (st_d.state == DATA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q        <= RX_RESET_STATE;
            byte_cnt_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_eop_q    <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_active_q <= rx_active_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_eop_q    <= rx_eop_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign rx.rx_active = rx_active_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.rx_data   = rx_data_q;
    assign rx.rx_eop    = rx_eop_q;
    assign rx.rx_err    = rx_err_q;

`ifdef USB_RX_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q + {15'd0, rx_eop_d};
        err_count_d = err_count_q + {15'd0, rx_err_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rx.pkt_count = pkt_count_q;
    assign rx.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench for usb_rx_deserializer: an NRZI/stuffing encoder builds line symbols
// tagged with expected bytes/EOPs, which feed a cycle-exact scoreboard.
module tb_usb_rx_deserializer;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    usb_rx_deserializer_if bus ();

    usb_rx_deserializer #(.SYNC_MIN(12), .STUFF_LEN(6)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (bus)
    );

    typedef struct {
        logic       lvl;
        logic       has_byte;
        logic [7:0] bval;
        logic       has_eop;
        logic       err;
        logic       act;
    } sym_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } byte_exp_t;

    typedef struct {
        int   cyc;
        logic err;
    } eop_exp_t;

    typedef struct {
        string       name;
        int          zeros;
        int          nbytes;
        logic [31:0] payload;
        logic        exp_sync;
        logic        exp_err;
    } vec_t;

    sym_t      sym_q[$];
    byte_exp_t byte_q[$];
    eop_exp_t  eop_q[$];
    vec_t      vecs[5];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   eop_total = 0;
    int   err_total = 0;
    logic line_tb = 1'b1;
    int   ones_run = 0;
    logic in_pkt = 1'b0;
    logic exp_active = 1'b0;
    logic mon_en = 1'b0;

    always @(posedge clock) cyc++;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushSym(input logic d, input logic hb, input logic [7:0] bv,
                           input logic he, input logic er, input logic act);
        sym_t s;
        if (!d) line_tb = ~line_tb;
        s.lvl      = line_tb;
        s.has_byte = hb;
        s.bval     = bv;
        s.has_eop  = he;
        s.err      = er;
        s.act      = act;
        sym_q.push_back(s);
    endtask

    task automatic encodeIdle(input int n);
        for (int i = 0; i < n; i++) pushSym(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic encodeSync(input int nz, input logic hit);
        for (int i = 0; i < nz; i++) pushSym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pushSym(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hit);
        in_pkt   = hit;
        ones_run = 1;
    endtask

    task automatic encodeBits(input logic [7:0] b, input int n, input logic tag_last);
        for (int i = 0; i < n; i++) begin
            pushSym(b[i], in_pkt && tag_last && (i == 7), b, 1'b0, 1'b0, in_pkt);
            ones_run = b[i] ? ones_run + 1 : 0;
            if (ones_run == 6) begin
                pushSym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, in_pkt);
                ones_run = 0;
            end
        end
    endtask

    task automatic encodeEop(input logic err);
        pushSym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, in_pkt);
        for (int i = 1; i <= 7; i++)
            pushSym(1'b1, 1'b0, 8'h00, in_pkt && (i == 7), err, in_pkt && (i < 7));
        in_pkt   = 1'b0;
        ones_run = 0;
    endtask

    task automatic applyTags(input sym_t s);
        byte_exp_t be;
        eop_exp_t  ee;
        if (s.has_byte) begin
            be.cyc  = cyc;
            be.data = s.bval;
            byte_q.push_back(be);
        end
        if (s.has_eop) begin
            ee.cyc = cyc;
            ee.err = s.err;
            eop_q.push_back(ee);
            eop_total++;
            if (s.err) err_total++;
        end
    endtask

    // Plays queued line symbols, optionally merging equal-level pairs into add cycles
    // and inserting drop cycles whose crd value must be ignored.
    task automatic applyStimulus(input int adds, input int drops);
        sym_t a;
        sym_t b;
        logic two;
        int   n = 0;
        while (sym_q.size() > 0) begin
            if (drops > 0 && (n % 4) == 2) begin
                bus.crd  = ~sym_q[0].lvl;
                bus.add  = 1'b0;
                bus.drop = 1'b1;
                @(posedge clock);
                #1;
                drops--;
                n++;
                continue;
            end
            a   = sym_q.pop_front();
            b   = a;
            two = 1'b0;
            if (adds > 0 && n >= 12 && sym_q.size() > 0 && sym_q[0].lvl == a.lvl) begin
                b   = sym_q.pop_front();
                two = 1'b1;
                adds--;
            end
            bus.crd  = a.lvl;
            bus.add  = two;
            bus.drop = 1'b0;
            @(posedge clock);
            #1;
            applyTags(a);
            if (two) applyTags(b);
            exp_active = two ? b.act : a.act;
            n++;
        end
        bus.add  = 1'b0;
        bus.drop = 1'b0;
    endtask

    task automatic checkOutput();
        byte_exp_t be;
        eop_exp_t  ee;
        cmp("rx_active", bus.rx_active, exp_active);
        if (byte_q.size() > 0 && byte_q[0].cyc == cyc) begin
            be = byte_q.pop_front();
            cmp("rx_valid", bus.rx_valid, 1);
            cmp("rx_data", bus.rx_data, be.data);
        end else begin
            cmp("no_valid", bus.rx_valid, 0);
            if (byte_q.size() > 0 && byte_q[0].cyc < cyc) begin
                be = byte_q.pop_front();
                cmp("missed_byte", bus.rx_valid, 1);
            end
        end
        if (eop_q.size() > 0 && eop_q[0].cyc == cyc) begin
            ee = eop_q.pop_front();
            cmp("rx_eop", bus.rx_eop, 1);
            cmp("rx_err", bus.rx_err, ee.err);
        end else begin
            cmp("no_eop", bus.rx_eop, 0);
            cmp("no_err", bus.rx_err, 0);
            if (eop_q.size() > 0 && eop_q[0].cyc < cyc) begin
                ee = eop_q.pop_front();
                cmp("missed_eop", bus.rx_eop, 1);
            end
        end
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, "_active"}, bus.rx_active, 0);
        cmp({tag, "_valid"}, bus.rx_valid, 0);
        cmp({tag, "_data"}, bus.rx_data, 0);
        cmp({tag, "_eop"}, bus.rx_eop, 0);
        cmp({tag, "_err"}, bus.rx_err, 0);
    endtask

    always @(negedge clock) begin
        if (mon_en) checkOutput();
    end

    initial begin
        vecs[0] = '{name: "a5",       zeros: 12, nbytes: 1, payload: 32'h0000_00A5, exp_sync: 1'b1, exp_err: 1'b0};
        vecs[1] = '{name: "ff00",     zeros: 12, nbytes: 2, payload: 32'h0000_00FF, exp_sync: 1'b1, exp_err: 1'b0};
        vecs[2] = '{name: "short",    zeros: 11, nbytes: 1, payload: 32'h0000_00A5, exp_sync: 1'b0, exp_err: 1'b0};
        vecs[3] = '{name: "empty",    zeros: 12, nbytes: 0, payload: 32'h0000_0000, exp_sync: 1'b1, exp_err: 1'b1};
        vecs[4] = '{name: "longsync", zeros: 20, nbytes: 3, payload: 32'h00FE_7E3C, exp_sync: 1'b1, exp_err: 1'b0};

        reset    = 1'b1;
        bus.crd  = 1'b1;
        bus.add  = 1'b0;
        bus.drop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkReset("reset");
        end
        reset      = 1'b0;
        exp_active = 1'b0;
        mon_en     = 1'b1;
        encodeIdle(20);
        applyStimulus(0, 0);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %s", vecs[v].name);
            encodeIdle(4);
            encodeSync(vecs[v].zeros, vecs[v].exp_sync);
            for (int j = 0; j < vecs[v].nbytes; j++) encodeBits(vecs[v].payload[8*j +: 8], 8, 1'b1);
            encodeEop(vecs[v].exp_err);
            applyStimulus(0, 0);
        end

        $display("[TB] retimed a5 with add/drop cycles");
        encodeIdle(4);
        encodeSync(12, 1'b1);
        encodeBits(8'hA5, 8, 1'b1);
        encodeEop(1'b0);
        encodeIdle(2);
        applyStimulus(2, 3);

        $display("[TB] reset mid-byte");
        encodeIdle(4);
        encodeSync(12, 1'b1);
        encodeBits(8'h3C, 8, 1'b1);
        encodeBits(8'hA5, 4, 1'b0);
        applyStimulus(0, 0);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        checkReset("midreset");
        cmp("midreset_pending_eop", eop_q.size(), 0);
        reset      = 1'b0;
        line_tb    = 1'b1;
        in_pkt     = 1'b0;
        ones_run   = 0;
        exp_active = 1'b0;
        mon_en     = 1'b1;
        encodeIdle(4);
        encodeSync(12, 1'b1);
        encodeBits(8'h5A, 8, 1'b1);
        encodeEop(1'b0);
        encodeIdle(4);
        applyStimulus(0, 0);

        mon_en = 1'b0;
        cmp("pending_bytes", byte_q.size(), 0);
        cmp("pending_eops", eop_q.size(), 0);
`ifdef USB_RX_STATS_EN
        cmp("pkt_count", bus.pkt_count, eop_total);
        cmp("err_count", bus.err_count, err_total);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
